spi_regif: RTL and testbench

SPI_REGIF -- requirements
Module: spi_regif

---
 rtl/spi_regif_if.sv | 24 ++
 rtl/spi_regif.sv | 162 ++++++++++++++++
 tb/tb_spi_regif.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_regif_if.sv
// Bundle of SPI pins and register-decoder signals shared by spi_regif and its host.
// slave is the SPI register interface side, master is the SPI host plus decoder side.
interface spi_regif_if;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       spioe;
  logic [3:0] addr;
  logic [7:0] wrtdata;
  logic [7:0] rddata;
  logic       we;
  logic       rdt;

  modport slave (
    input  ss, sclk, mosi, rddata,
    output miso, spioe, addr, wrtdata, we, rdt
  );

  modport master (
    output ss, sclk, mosi, rddata,
    input  miso, spioe, addr, wrtdata, we, rdt
  );
endinterface

// File: rtl/spi_regif.sv
// SPI mode-0 slave turning 16-bit frames {rw,3'b0,addr[3:0]} + data into register strobes.
// All SPI pins are oversampled in the clk domain through SYNCSTAGES-deep synchronizers.
//
//   state | meaning
//   IDLE  | waiting for a synchronized ss falling edge
//   CMD   | shifting in the command byte (sclk rises 1-8)
//   DATA  | shifting the data byte in, read data out (rises 9-16)
//   DONE  | frame complete, extra sclk edges ignored until ss rises
module spi_regif #(
  parameter int SYNCSTAGES = 2
) (
  input logic        clk,
  input logic        rstn,
  spi_regif_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SYNCSTAGES-1:0] ss_sync_q;
  logic [SYNCSTAGES-1:0] sclk_sync_q;
  logic [SYNCSTAGES-1:0] mosi_sync_q;
  logic                  ss_d1_q;
  logic                  sclk_d1_q;
  logic [SYNCSTAGES:0]   flush_q;
  logic [3:0]            bitcnt_q, bitcnt_d;
  logic [6:0]            rx_q, rx_d;
  logic [7:0]            tx_q, tx_d;
  logic [3:0]            addr_q, addr_d;
  logic [7:0]            wrtdata_q, wrtdata_d;
  logic                  rw_q, rw_d;
  logic                  we_q, we_d;
  logic                  rdt_q, rdt_d;

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  assign ss_s   = ss_sync_q[SYNCSTAGES-1];
  assign sclk_s = sclk_sync_q[SYNCSTAGES-1];
  assign mosi_s = mosi_sync_q[SYNCSTAGES-1];

  // The synchronizers come out of reset at idle levels; a fall is only trusted once
  // the pipeline holds real samples, so ss already low at reset release is not a frame.
  assign ss_fall   = flush_q[SYNCSTAGES] & ss_d1_q & ~ss_s;
  assign ss_rise   = ~ss_d1_q & ss_s;
  assign sclk_rise = ~sclk_d1_q & sclk_s;
  assign sclk_fall = sclk_d1_q & ~sclk_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_d1_q     <= 1'b1;
      sclk_d1_q   <= 1'b0;
      flush_q     <= '0;
      state_q     <= IDLE;
      bitcnt_q    <= 4'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'd0;
      addr_q      <= 4'd0;
      wrtdata_q   <= 8'd0;
      rw_q        <= 1'b0;
      we_q        <= 1'b0;
      rdt_q       <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNCSTAGES-2:0], bus.ss};
      sclk_sync_q <= {sclk_sync_q[SYNCSTAGES-2:0], bus.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNCSTAGES-2:0], bus.mosi};
      ss_d1_q     <= ss_s;
      sclk_d1_q   <= sclk_s;
      flush_q     <= {flush_q[SYNCSTAGES-1:0], 1'b1};
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      wrtdata_q   <= wrtdata_d;
      rw_q        <= rw_d;
      we_q        <= we_d;
      rdt_q       <= rdt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wrtdata_d = wrtdata_q;
    rw_d      = rw_q;
    we_d      = 1'b0;
    rdt_d     = 1'b0;

    // Read data is captured the clk after rdt, before any clear-on-read side effect lands.
    if (rdt_q) begin
      tx_d = bus.rddata;
    end

    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_d  = CMD;
            bitcnt_d = 4'd0;
            tx_d     = 8'd0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rx_d     = {rx_q[5:0], mosi_s};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              addr_d  = {rx_q[2:0], mosi_s};
              rw_d    = rx_q[6];
              rdt_d   = ~rx_q[6];
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            rx_d     = {rx_q[5:0], mosi_s};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd15) begin
              state_d = DONE;
              if (rw_q) begin
                wrtdata_d = {rx_q, mosi_s};
                we_d      = 1'b1;
              end
            end
          // The fall right after the 8th rise must not shift: data bit 7 is still unsent.
          end else if (sclk_fall && (bitcnt_q != 4'd8)) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.miso    = (state_q == DATA) && !rw_q && tx_q[7];
  assign bus.spioe   = ~ss_s;
  assign bus.addr    = addr_q;
  assign bus.wrtdata = wrtdata_q;
  assign bus.we      = we_q;
  assign bus.rdt     = rdt_q;

endmodule

// File: tb/tb_spi_regif.sv
// Self-checking bench for spi_regif: directed frame table, reset/back-to-back sequences,
// and random frames scored against a frame-level model of the register protocol.
module tb_spi_regif;
  localparam int SYNC = 2;
  localparam int H    = 6;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [7:0] rdd;
    int         nrise;
    logic       exp_we;
    logic       exp_rdt;
    logic [3:0] exp_addr;
    logic [7:0] exp_wrt;
    logic [7:0] exp_miso;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  spi_regif_if bus ();

  spi_regif #(.SYNCSTAGES(SYNC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_pass = 0;
  int   we_cnt = 0;
  int   rdt_cnt = 0;
  int   we_cyc = -1;
  int   rdt_cyc = -1;
  logic both_hi = 1'b0;
  logic [7:0] we_data = 8'h00;
  byte  ev_q[$];
  int   rise_cyc[32];

  always @(negedge clk) begin
    if (bus.we) begin
      we_cnt  = we_cnt + 1;
      we_cyc  = cyc;
      we_data = bus.wrtdata;
      ev_q.push_back("W");
    end
    if (bus.rdt) begin
      rdt_cnt = rdt_cnt + 1;
      rdt_cyc = cyc;
      ev_q.push_back("R");
    end
    if (bus.we && bus.rdt) both_hi = 1'b1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // One mode-0 bit: mosi set, half period, sample miso, rise, half period, fall.
  task automatic clock_bit(input logic b, input int k, output logic m);
    bus.mosi = b;
    wait_clks(H);
    m = bus.miso;
    bus.sclk = 1'b1;
    rise_cyc[k] = cyc;
    wait_clks(H);
    bus.sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dat, input logic [7:0] rdd,
                           input int nrise, input int gap,
                           output logic [7:0] miso_cmd, output logic [7:0] miso_dat);
    logic b, m;
    bus.rddata = rdd;
    miso_cmd = 8'h00;
    miso_dat = 8'h00;
    bus.ss = 1'b0;
    wait_clks(H);
    for (int k = 1; k <= nrise; k++) begin
      if (k <= 8) b = cmd[8-k];
      else if (k <= 16) b = dat[16-k];
      else b = 1'($urandom_range(0, 1));
      clock_bit(b, k, m);
      if (k <= 8) miso_cmd[8-k] = m;
      else if (k <= 16) miso_dat[16-k] = m;
    end
    bus.mosi = 1'b0;
    wait_clks(H);
    bus.ss = 1'b1;
    wait_clks(gap);
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int we0, input int rdt0,
                             input logic [7:0] mc, input logic [7:0] md);
    logic [7:0] mask;
    mask = 8'h00;
    for (int k = 9; k <= 16; k++) if (k <= v.nrise) mask[16-k] = 1'b1;
    chk({tag, ".we_cnt"},  32'(we_cnt - we0),   32'(v.exp_we));
    chk({tag, ".rdt_cnt"}, 32'(rdt_cnt - rdt0), 32'(v.exp_rdt));
    chk({tag, ".addr"},    32'(bus.addr),       32'(v.exp_addr));
    chk({tag, ".wrtdata"}, 32'(bus.wrtdata),    32'(v.exp_wrt));
    chk({tag, ".miso_cmd"}, 32'(mc), 32'h0);
    chk({tag, ".miso_dat"}, 32'(md & mask), 32'(v.exp_miso & mask));
    chk({tag, ".spioe_idle"}, 32'(bus.spioe), 32'h0);
    if (v.exp_rdt) chk({tag, ".rdt_lat"}, 32'(rdt_cyc - rise_cyc[8]), 32'(SYNC + 1));
    if (v.exp_we) begin
      chk({tag, ".we_lat"},  32'(we_cyc - rise_cyc[16]), 32'(SYNC + 1));
      chk({tag, ".we_data"}, 32'(we_data), 32'(v.exp_wrt));
    end
  endtask

  vec_t tbl[6];

  initial begin
    logic [7:0] mc, md;
    logic       m;
    int         we0, rdt0;
    logic [3:0] m_addr;
    logic [7:0] m_wrt;
    vec_t       v;

    tbl[0] = '{8'h80, 8'h5A, 8'h00, 16, 1'b1, 1'b0, 4'h0, 8'h5A, 8'h00};
    tbl[1] = '{8'h0F, 8'h00, 8'hC3, 16, 1'b0, 1'b1, 4'hF, 8'h5A, 8'hC3};
    tbl[2] = '{8'h84, 8'hFF, 8'h00, 12, 1'b0, 1'b0, 4'h4, 8'h5A, 8'h00};
    tbl[3] = '{8'h8E, 8'h10, 8'hAA, 24, 1'b1, 1'b0, 4'hE, 8'h10, 8'h00};
    tbl[4] = '{8'hF7, 8'h3C, 8'h00, 16, 1'b1, 1'b0, 4'h7, 8'h3C, 8'h00};
    tbl[5] = '{8'h02, 8'h00, 8'h96, 10, 1'b0, 1'b1, 4'h2, 8'h3C, 8'h96};

    bus.ss = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0; bus.rddata = 8'h00;
    wait_clks(2);
    bus.ss = 1'b0; bus.sclk = 1'b1; bus.mosi = 1'b1;
    wait_clks(4);
    chk("reset.outputs", 32'({bus.miso, bus.spioe, bus.addr, bus.wrtdata, bus.we, bus.rdt}), 32'h0);
    bus.ss = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    wait_clks(2);
    rstn = 1'b1;
    wait_clks(5);

    for (int i = 0; i < 6; i++) begin
      we0 = we_cnt; rdt0 = rdt_cnt;
      run_frame(tbl[i].cmd, tbl[i].dat, tbl[i].rdd, tbl[i].nrise, 6, mc, md);
      check_frame($sformatf("tbl%0d", i), tbl[i], we0, rdt0, mc, md);
    end

    // Reset after the 5th rise; ss stays low across release, so the rest must be ignored.
    we0 = we_cnt; rdt0 = rdt_cnt;
    bus.ss = 1'b0;
    wait_clks(H);
    for (int k = 1; k <= 5; k++) clock_bit(tbl[0].cmd[8-k] ^ (k == 5), k, m);
    rstn = 1'b0;
    wait_clks(3);
    chk("midrst.in_reset", 32'({bus.addr, bus.wrtdata, bus.we, bus.rdt, bus.spioe}), 32'h0);
    rstn = 1'b1;
    for (int k = 6; k <= 16; k++) clock_bit(1'b1, k, m);
    wait_clks(H);
    bus.ss = 1'b1;
    wait_clks(6);
    chk("midrst.no_strobe", 32'((we_cnt - we0) + (rdt_cnt - rdt0)), 32'h0);
    chk("midrst.addr_kept", 32'({bus.addr, bus.wrtdata}), 32'h0);
    we0 = we_cnt; rdt0 = rdt_cnt;
    v = '{8'h82, 8'h01, 8'h00, 16, 1'b1, 1'b0, 4'h2, 8'h01, 8'h00};
    run_frame(v.cmd, v.dat, v.rdd, v.nrise, 6, mc, md);
    check_frame("midrst.clean", v, we0, rdt0, mc, md);

    // Back-to-back: read addr 4, ss high for only 4 clks, then write 8'h33 to addr 8.
    ev_q.delete();
    we0 = we_cnt; rdt0 = rdt_cnt;
    v = '{8'h04, 8'h00, 8'h5E, 16, 1'b0, 1'b1, 4'h4, 8'h01, 8'h5E};
    run_frame(v.cmd, v.dat, v.rdd, v.nrise, 4, mc, md);
    check_frame("b2b.rd", v, we0, rdt0, mc, md);
    we0 = we_cnt; rdt0 = rdt_cnt;
    v = '{8'h88, 8'h33, 8'h00, 16, 1'b1, 1'b0, 4'h8, 8'h33, 8'h00};
    run_frame(v.cmd, v.dat, v.rdd, v.nrise, 6, mc, md);
    check_frame("b2b.wr", v, we0, rdt0, mc, md);
    chk("b2b.ev_count", 32'(ev_q.size()), 32'd2);
    if (ev_q.size() == 2) chk("b2b.ev_order", 32'({ev_q[0], ev_q[1]}), 32'({8'h52, 8'h57}));

    // Random frames against a frame-level model: what a complete/partial frame must leave behind.
    m_addr = 4'h8;
    m_wrt  = 8'h33;
    for (int i = 0; i < 24; i++) begin
      logic       rw;
      logic [3:0] a;
      int         sel;
      rw  = 1'($urandom_range(0, 1));
      a   = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 5);
      v.cmd   = {rw, 3'($urandom_range(0, 7)), a};
      v.dat   = 8'($urandom_range(0, 255));
      v.rdd   = 8'($urandom_range(0, 255));
      v.nrise = (sel < 4) ? 16 : (sel == 4) ? 16 + $urandom_range(1, 8) : $urandom_range(1, 15);
      v.exp_rdt = !rw && (v.nrise >= 8);
      v.exp_we  = rw && (v.nrise >= 16);
      if (v.nrise >= 8) m_addr = a;
      if (v.exp_we) m_wrt = v.dat;
      v.exp_addr = m_addr;
      v.exp_wrt  = m_wrt;
      v.exp_miso = rw ? 8'h00 : v.rdd;
      we0 = we_cnt; rdt0 = rdt_cnt;
      run_frame(v.cmd, v.dat, v.rdd, v.nrise, 2 + $urandom_range(0, 6), mc, md);
      check_frame($sformatf("rnd%0d", i), v, we0, rdt0, mc, md);
    end

    chk("we_rdt_exclusive", 32'(both_hi), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
